// File: rtl/obf_seq_ctrl.sv
// Upstream sequencer for the obfuscation LUT stage. It walks the sub-instruction
// pointer through a LUT substitution sequence, or bypasses unobfuscated instructions.
module obf_seq_ctrl #(
  parameter int IGU_WIDTH = 6,
  parameter int PPC_WIDTH = 4,
  parameter int KEY_WIDTH = 8,
  parameter int OUT_WIDTH = 32,
  parameter int LAST_BIT  = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OUT_WIDTH-1:0] in_insn,
  input  logic [IGU_WIDTH-1:0] in_index,
  input  logic [KEY_WIDTH-1:0] in_key,
  input  logic                 pipe_stall,
  output logic [IGU_WIDTH-1:0] lut_index,
  output logic [PPC_WIDTH-1:0] lut_ppc,
  output logic [KEY_WIDTH-1:0] lut_key,
  input  logic [OUT_WIDTH-1:0] lut_sub,
  input  logic [OUT_WIDTH-1:0] lut_imm,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_insn,
  output logic [OUT_WIDTH-1:0] out_imm,
  output logic                 out_last,
  output logic                 busy,
  output logic                 err_overrun
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_BYPASS = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IGU_WIDTH-1:0] lut_index_q, lut_index_d;
  logic [PPC_WIDTH-1:0] lut_ppc_q, lut_ppc_d;
  logic [KEY_WIDTH-1:0] lut_key_q, lut_key_d;
  logic [OUT_WIDTH-1:0] insn_q, insn_d;
  logic                 err_overrun_q, err_overrun_d;

  logic ppc_max_s;
  logic sub_last_s;
  logic done_s;
  logic accept_s;

  assign lut_index   = lut_index_q;
  assign lut_ppc     = lut_ppc_q;
  assign lut_key     = lut_key_q;
  assign err_overrun = err_overrun_q;
  assign busy        = (state_q != ST_IDLE);

  assign ppc_max_s  = &lut_ppc_q;
  assign sub_last_s = lut_sub[LAST_BIT];
  // A word completes when it is last and downstream takes it; that frees fetch.
  assign done_s     = (state_q != ST_IDLE) && out_last && !pipe_stall;
  assign in_ready   = (state_q == ST_IDLE) || done_s;
  assign accept_s   = in_valid && in_ready;

  // Output word selection from current state and LUT response
  always_comb begin
    out_valid = 1'b0;
    out_insn  = {OUT_WIDTH{1'b0}};
    out_imm   = {OUT_WIDTH{1'b0}};
    out_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        out_valid = 1'b0;
      end
      ST_EXPAND: begin
        out_valid = 1'b1;
        out_insn  = lut_sub;
        out_imm   = lut_imm;
        out_last  = sub_last_s || ppc_max_s;
      end
      ST_BYPASS: begin
        out_valid = 1'b1;
        out_insn  = insn_q;
        out_last  = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  // Next-state and pointer sequencing
  always_comb begin
    state_d     = state_q;
    lut_index_d = lut_index_q;
    lut_ppc_d   = lut_ppc_q;
    lut_key_d   = lut_key_q;
    insn_d      = insn_q;
    if (accept_s) begin
      lut_index_d = in_index;
      lut_key_d   = in_key;
      insn_d      = in_insn;
      lut_ppc_d   = {PPC_WIDTH{1'b0}};
      state_d     = (in_index == {IGU_WIDTH{1'b0}}) ? ST_BYPASS : ST_EXPAND;
    end else if (done_s) begin
      state_d = ST_IDLE;
    end else if ((state_q == ST_EXPAND) && !pipe_stall) begin
      lut_ppc_d = lut_ppc_q + {{(PPC_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      state_d = state_q;
    end

    // Running off the end of the pointer range without a LAST marker is a LUT fault.
    if ((state_q == ST_EXPAND) && done_s && ppc_max_s && !sub_last_s) begin
      err_overrun_d = 1'b1;
    end else begin
      err_overrun_d = err_overrun_q;
    end
  end

  // State and LUT request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      lut_index_q   <= {IGU_WIDTH{1'b0}};
      lut_ppc_q     <= {PPC_WIDTH{1'b0}};
      lut_key_q     <= {KEY_WIDTH{1'b0}};
      insn_q        <= {OUT_WIDTH{1'b0}};
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lut_index_q   <= lut_index_d;
      lut_ppc_q     <= lut_ppc_d;
      lut_key_q     <= lut_key_d;
      insn_q        <= insn_d;
      err_overrun_q <= err_overrun_d;
    end
  end

endmodule

// File: doc/obf_seq_ctrl.md
Name: obf_seq_ctrl

Overview:
- Upstream sequencer for the obfuscation LUT stage.
- Accepts one fetched instruction plus its IGU group index and key, then steps the sub-instruction pointer (ppc) from 0 through the LUT's substitution sequence, one word per cycle.
- Presents each LUT word to the decode side with valid/last flags and holds fetch via a ready handshake.
- Index 0 means "not obfuscated": the original instruction passes through in one cycle.

Parameters:
- IGU_WIDTH, 6, width of the group index driven to the LUT
- PPC_WIDTH, 4, width of the sub-instruction pointer
- KEY_WIDTH, 8, width of the obfuscation key
- OUT_WIDTH, 32, width of LUT sub/imm words and instruction
- LAST_BIT, 31, bit of lut_sub marking the final word of a sequence

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  fetched instruction available
- in_ready  out  1  sequencer accepts instruction this cycle
- in_insn  in  OUT_WIDTH  original instruction (used for bypass)
- in_index  in  IGU_WIDTH  group index; 0 = bypass
- in_key  in  KEY_WIDTH  key for this instruction
- pipe_stall  in  1  downstream cannot take a word this cycle
- lut_index  out  IGU_WIDTH  registered index to the LUT
- lut_ppc  out  PPC_WIDTH  registered pointer to the LUT
- lut_key  out  KEY_WIDTH  registered key to the LUT
- lut_sub  in  OUT_WIDTH  LUT substitution word (combinational from lut_*)
- lut_imm  in  OUT_WIDTH  LUT immediate word
- out_valid  out  1  out_insn/out_imm valid
- out_insn  out  OUT_WIDTH  emitted instruction word
- out_imm  out  OUT_WIDTH  emitted immediate (0 in bypass)
- out_last  out  1  final word of the current instruction
- busy  out  1  state != IDLE
- err_overrun  out  1  sticky: sequence hit max ppc without LAST_BIT

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - State IDLE.
  - lut_index, lut_ppc, lut_key, the held insn register, out_valid, out_last and err_overrun all 0.
  - in_ready = 1 after reset.
- States: IDLE, EXPAND, BYPASS.
- Accept condition: "accept" = in_valid && in_ready.
  - Latches in_index→lut_index, in_key→lut_key and in_insn→held register; sets ppc=0.
  - Next state is BYPASS if in_index==0, else EXPAND.
- IDLE: out_valid=0; in_ready=1.
- EXPAND:
  - out_valid=1, out_insn=lut_sub, out_imm=lut_imm, out_last=lut_sub[LAST_BIT] || (lut_ppc==all-ones).
  - If pipe_stall: hold all state; outputs stable.
  - Else if out_last: the word is consumed and the block goes to IDLE, unless accepting in the same cycle.
  - Else: ppc increments by 1.
- BYPASS:
  - out_valid=1, out_insn=held insn, out_imm=0, out_last=1.
  - Completes when !pipe_stall.
- Back-to-back: in_ready=1 in the cycle the last word completes, i.e. state in {EXPAND, BYPASS} && out_last && !pipe_stall.
  - A new accept in that cycle transitions directly to EXPAND/BYPASS with ppc=0, with no IDLE bubble.
- Overrun: if lut_ppc==all-ones and lut_sub[LAST_BIT]==0 when the word completes, set err_overrun (sticky until rst) and treat it as last. ppc never wraps.
- Outputs: out_* are combinational from state plus the LUT response. lut_* are registered, giving 1 cycle from accept to first out_valid.
- Reset mid-EXPAND: next cycle IDLE, out_valid=0, ppc=0; the partial sequence is discarded.
- busy = (state != IDLE).

Test Plan:
- Bypass: rst, then in_valid with in_index=0, in_insn=0x15000000 and no stall.
  - Next cycle: out_valid=1, out_insn=0x15000000, out_imm=0, out_last=1.
  - The cycle after: out_valid=0, busy=0.
- 3-word sequence: LUT model returns last on ppc=2 for index 5; accept index 5, key 0xA5.
  - lut_ppc=0,1,2 on consecutive cycles; out_last only on ppc=2; lut_key=0xA5 throughout.
- Stall hold: during the index-5 sequence, assert pipe_stall for 2 cycles at ppc=1.
  - lut_ppc stays 1, out_insn is unchanged, in_ready=0.
  - Sequence resumes with ppc=2 after the stall is released.
- Back-to-back: hold in_valid high with index 5 then index 0.
  - in_ready=1 on the ppc=2 cycle; the bypass word appears the next cycle with no bubble.
- Overrun: LUT model never sets LAST_BIT.
  - ppc runs 0..15; the word at ppc=15 has out_last=1; err_overrun=1 from the next cycle and stays set.
  - The next instruction is accepted normally.
- Reset mid-op: assert rst at ppc=1.
  - Next cycle: state IDLE, out_valid=0, lut_ppc=0, err_overrun=0, in_ready=1.
